// File: rtl/ocimem_seq_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory access sequencer.
package ocimem_seq_pkg;
  typedef enum logic {IDLE, ACCESS} state_e;
  typedef enum logic {CMD_RD, CMD_WR} cmd_e;

  localparam int ADDR_LSB  = 17;
  localparam int RDNOW_BIT = 35;
  localparam int WDATA_LSB = 3;
  localparam int WDATA_MSB = 34;
endpackage

// File: rtl/ocimem_seq_timer.sv
// Saturating up-counter for the access watchdog. A load restarts the count at 1,
// so the count equals the number of cycles spent in the access, including the current one.
module ocimem_seq_timer #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_cnt <= '0;
    else if (i_load)                   r_cnt <= W'(1);
    else if (i_en && r_cnt != W'(MAX)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == W'(MAX));
endmodule

// File: rtl/ocimem_access_sequencer.sv
// Sequences debugger accesses to the OCI RAM over a req/ack port.
// Optional watchdog on outstanding accesses: define OCIMEM_SEQ_TIMEOUT_EN.
module ocimem_access_sequencer
  import ocimem_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  state_e            r_state, w_state_nxt;
  cmd_e              r_cmd,   w_cmd_nxt;
  logic              r_incr,  w_incr_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [DATA_W-1:0] r_data,  w_data_nxt;
  logic              r_rdy,   w_rdy_nxt;
  logic              r_err,   w_err_nxt;
  logic              w_accept;
  logic              w_any_strobe;
  logic              w_tmr_tc;

  wire [ADDR_W-1:0] w_jdo_addr  = jdo[ADDR_LSB+ADDR_W-1:ADDR_LSB];
  wire              w_jdo_rdnow = jdo[RDNOW_BIT];
  wire [DATA_W-1:0] w_jdo_wdata = jdo[WDATA_MSB:WDATA_LSB];
  wire [4:0]        w_unused_jdo = {jdo[37:36], jdo[2:0]};

  assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

`ifdef OCIMEM_SEQ_TIMEOUT_EN
  ocimem_seq_timer #(.MAX(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_en   (r_state == ACCESS),
    .o_tc   (w_tmr_tc)
  );
`else
  wire w_unused_to = (TIMEOUT_CYC == 0);
  assign w_tmr_tc = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd   <= CMD_RD;
      r_incr  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_incr  <= w_incr_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_rdy   <= w_rdy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Strobe priority in IDLE is a > b > no_action; losers are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_incr_nxt  = r_incr;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_rdy_nxt   = r_rdy;
    w_err_nxt   = r_err;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          w_addr_nxt = w_jdo_addr;
          w_err_nxt  = 1'b0;
          if (w_jdo_rdnow) begin
            w_accept   = 1'b1;
            w_cmd_nxt  = CMD_RD;
            w_incr_nxt = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          w_accept   = 1'b1;
          w_data_nxt = w_jdo_wdata;
          w_cmd_nxt  = CMD_WR;
          w_incr_nxt = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          w_accept   = 1'b1;
          w_cmd_nxt  = CMD_RD;
          w_incr_nxt = 1'b1;
        end
        if (w_accept) begin
          w_state_nxt = ACCESS;
          w_rdy_nxt   = 1'b0;
        end
      end
      ACCESS: begin
        if (w_any_strobe) w_err_nxt = 1'b1;
        // An ack coinciding with the watchdog expiry still completes normally.
        if (mem_ack) begin
          if (r_cmd == CMD_RD) w_data_nxt = mem_rdata;
          if (r_incr)          w_addr_nxt = r_addr + 1'b1;
          w_state_nxt = IDLE;
          w_rdy_nxt   = 1'b1;
        end else if (w_tmr_tc) begin
          w_state_nxt = IDLE;
          w_rdy_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_req       = (r_state == ACCESS);
  assign mem_we        = mem_req & (r_cmd == CMD_WR);
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_data;
  assign MonAReg       = r_addr;
  assign MonDReg       = r_data;
  assign monitor_ready = r_rdy;
  assign monitor_error = r_err;
endmodule

// File: tb/tb_ocimem_access_sequencer.sv
// Bench for ocimem_access_sequencer: directed scenarios plus random strobes/acks
// checked every cycle against a transaction-level model.
module tb_ocimem_access_sequencer;
  localparam int AW = 8;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a, mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, monitor_ready, monitor_error;
  logic [AW-1:0] mem_addr, MonAReg;
  logic [31:0] mem_wdata, MonDReg;

  ocimem_access_sequencer #(.ADDR_W(AW), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna_a),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .MonAReg(MonAReg), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: monitor registers plus one pending transaction record.
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  bit            m_busy, m_wr, m_inc, m_rdy, m_err;
  int            m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_data = '0; m_busy = 0; m_wr = 0; m_inc = 0;
    m_rdy = 1; m_err = 0; m_wait = 0;
  endtask

  task automatic chk_all();
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) begin
      chk("mem_we",    32'(mem_we),   32'(m_wr));
      chk("mem_addr",  32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", mem_wdata,     m_data);
    end
    chk("MonAReg",       32'(MonAReg),       32'(m_addr));
    chk("MonDReg",       MonDReg,            m_data);
    chk("monitor_ready", 32'(monitor_ready), 32'(m_rdy));
    chk("monitor_error", 32'(monitor_error), 32'(m_err));
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_edge(input bit a, b, na, input logic [37:0] j, input bit ack,
                            input logic [31:0] rd);
    if (!m_busy) begin
      if (a) begin
        m_addr = j[17+AW-1:17];
        m_err  = 0;
        if (j[35]) begin m_busy = 1; m_wr = 0; m_inc = 0; end
      end else if (b) begin
        m_data = j[34:3]; m_busy = 1; m_wr = 1; m_inc = 1;
      end else if (na) begin
        m_busy = 1; m_wr = 0; m_inc = 1;
      end
      if (m_busy) begin m_rdy = 0; m_wait = 0; end
    end else begin
      if (a || b || na) m_err = 1;
      m_wait++;
      if (ack) begin
        if (!m_wr) m_data = rd;
        if (m_inc) m_addr = m_addr + 1'b1;
        m_busy = 0; m_rdy = 1;
      end
`ifdef OCIMEM_SEQ_TIMEOUT_EN
      else if (m_wait == TO) begin
        m_busy = 0; m_rdy = 1; m_err = 1;
      end
`endif
    end
  endtask

  task automatic step(input bit a, b, na, input logic [37:0] j, input bit ack,
                      input logic [31:0] rd);
    @(negedge clk);
    chk_all();
    ta_a = a; ta_b = b; tna_a = na; jdo = j; mem_ack = ack; mem_rdata = rd;
    model_edge(a, b, na, j, ack, rd);
  endtask

  function automatic logic [37:0] mk_jdo(input logic [AW-1:0] ad, input bit rdnow,
                                         input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    j[34:3] = wd;
    j[35] = rdnow;
    j[17+AW-1:17] = ad;
    return j;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    logic [63:0]   r64;
    logic [AW-1:0] saved;
    reset = 1; ta_a = 0; ta_b = 0; tna_a = 0; jdo = '0; mem_ack = 0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(mem_req), 0);
    chk("rst_we",    32'(mem_we), 0);
    chk("rst_areg",  32'(MonAReg), 0);
    chk("rst_dreg",  MonDReg, 0);
    chk("rst_ready", 32'(monitor_ready), 1);
    chk("rst_error", 32'(monitor_error), 0);
    reset = 0;

    // Address load without read.
    step(1, 0, 0, mk_jdo(8'h10, 0, 32'h0), 0, '0);
    idle(1);
    chk("load_areg", 32'(MonAReg), 32'h10);
    chk("load_noreq", 32'(mem_req), 0);

    // Write, ack after 3 cycles.
    step(0, 1, 0, {3'b000, 32'hDEADBEEF, 3'b000}, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 1, '0);
    idle(1);
    chk("wr_areg", 32'(MonAReg), 32'h11);
    chk("wr_ready", 32'(monitor_ready), 1);

    // Read with address wrap.
    step(1, 0, 0, mk_jdo(8'hFF, 0, '0), 0, '0);
    step(0, 0, 1, '0, 0, '0);
    step(0, 0, 0, '0, 1, 32'h12345678);
    idle(1);
    chk("rdwrap_dreg", MonDReg, 32'h12345678);
    chk("rdwrap_areg", 32'(MonAReg), 0);

    // Collision during an outstanding read, then clear via ocimem_a.
    step(0, 0, 1, '0, 0, '0);
    step(0, 1, 0, {3'b000, 32'hCAFEF00D, 3'b000}, 0, '0);
    step(0, 0, 0, '0, 1, 32'hA5A5A5A5);
    idle(1);
    chk("busy_err", 32'(monitor_error), 1);
    chk("busy_rd", MonDReg, 32'hA5A5A5A5);
    step(1, 0, 0, mk_jdo(8'h05, 0, '0), 0, '0);
    idle(1);
    chk("busy_clr", 32'(monitor_error), 0);

    // Simultaneous a+b: only the address loads.
    step(1, 1, 0, mk_jdo(8'h20, 0, 32'h0), 0, '0);
    idle(1);
    chk("simul_areg", 32'(MonAReg), 32'h20);
    chk("simul_noreq", 32'(mem_req), 0);

    // RDNOW read: completes without incrementing; stray ack in IDLE ignored.
    step(1, 0, 0, mk_jdo(8'h30, 1, '0), 0, '0);
    step(0, 0, 0, '0, 1, 32'h0BADCAFE);
    step(0, 0, 0, '0, 1, 32'h11111111);
    idle(1);
    chk("rdnow_areg", 32'(MonAReg), 32'h30);
    chk("rdnow_dreg", MonDReg, 32'h0BADCAFE);

`ifdef OCIMEM_SEQ_TIMEOUT_EN
    saved = MonAReg;
    step(0, 0, 1, '0, 0, '0);
    idle(TO + 2);
    chk("to_err", 32'(monitor_error), 1);
    chk("to_areg", 32'(MonAReg), 32'(saved));
`endif

    // Asynchronous reset mid-access.
    step(0, 0, 1, '0, 0, '0);
    @(negedge clk);
    chk_all();
    ta_a = 0; ta_b = 0; tna_a = 0; mem_ack = 0;
    #2 reset = 1;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_ready", 32'(monitor_ready), 1);
    model_reset();
    @(negedge clk);
    reset = 0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit a, b, na, ack;
      r64 = {$urandom(), $urandom()};
      a   = ($urandom_range(0, 7) == 0);
      b   = ($urandom_range(0, 7) == 0);
      na  = ($urandom_range(0, 5) == 0);
      ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      step(a, b, na, r64[37:0], ack, $urandom());
    end
    @(negedge clk);
    chk_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ocimem_access_sequencer.md
Name: ocimem_access_sequencer

Overview:
- Sequences debugger-initiated accesses to the on-chip debug memory (OCI RAM) of the Nios II JTAG debug module.
- Consumes the system-clock-domain `take_action_ocimem_*` strobes and the 38-bit `jdo` shift data produced by the debug module's sysclk half.
- Owns the monitor address/data registers and drives a single req/ack memory port.
- Reports `monitor_ready` and `monitor_error` back to the JTAG capture path.

Parameters:
- ADDR_W, 8, word-address width of the debug memory.
- DATA_W, 32, data width; fixed at 32 because `jdo` carries 32 data bits.
- TIMEOUT_CYC, 255, maximum cycles to wait for `mem_ack` before flagging an error (only used with the optional feature).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  JTAG data-out shift contents, sampled on strobe cycles.
- take_action_ocimem_a  in  1  strobe: load address; optionally start a read.
- take_action_ocimem_b  in  1  strobe: write data, then post-increment the address.
- take_no_action_ocimem_a  in  1  strobe: read at the current address, then post-increment.
- mem_req  out  1  memory request; held high until ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_addr  out  ADDR_W  word address; stable while mem_req is high.
- mem_wdata  out  32  write data.
- mem_ack  in  1  one-cycle completion; read data valid the same cycle.
- mem_rdata  in  32  read data.
- MonAReg  out  ADDR_W  current monitor address.
- MonDReg  out  32  last written or last read data.
- monitor_ready  out  1  level: no access outstanding and last command completed.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, except `monitor_ready` = 1; state = IDLE. Reset asserted mid-access drops `mem_req` immediately (asynchronous); the memory side must tolerate an abandoned request.
- jdo fields:
  - ADDR = jdo[17+ADDR_W-1:17]
  - RDNOW = jdo[35]
  - WDATA = jdo[34:3]
- Priority when strobes coincide: ocimem_a > ocimem_b > no_action_a. Lower-priority strobes in the same cycle are discarded silently.
- IDLE:
  - ocimem_a: MonAReg <= ADDR; monitor_error <= 0. If RDNOW, go to ACCESS as a read; else remain IDLE with monitor_ready = 1.
  - ocimem_b: MonDReg <= WDATA; go to ACCESS as a write.
  - no_action_a: go to ACCESS as a read.
- Any accepted access: monitor_ready <= 0 in the same edge. `mem_req` rises the cycle after the strobe (1-cycle issue latency).
- ACCESS:
  - mem_req = 1, mem_addr = MonAReg, mem_we per command, mem_wdata = MonDReg.
  - On mem_ack: for a read, MonDReg <= mem_rdata. MonAReg <= MonAReg + 1, wrapping modulo 2^ADDR_W with no flag. A plain address load (ocimem_a) never increments, including when its RDNOW read completes.
  - After mem_ack: mem_req <= 0, monitor_ready <= 1, return to IDLE. The next access can be accepted the cycle after return.
- Any strobe arriving in ACCESS is ignored and sets monitor_error <= 1. The current access continues unaffected.
- mem_ack while in IDLE is ignored.

Optional Feature:
- Macro: OCIMEM_SEQ_TIMEOUT_EN.
- Defined:
  - ACCESS runs a cycle counter, cleared on entry.
  - If it reaches TIMEOUT_CYC without mem_ack: mem_req <= 0, monitor_error <= 1, monitor_ready <= 1, MonDReg unchanged, no address increment, return to IDLE.
  - An ack in the same cycle as the timeout wins: treated as normal completion.
- Undefined: no counter; ACCESS waits indefinitely for mem_ack.

Decomposition:
- Shared package `ocimem_seq_pkg`:
  - state enum {IDLE, ACCESS}
  - command enum {CMD_RD, CMD_WR}
  - jdo field position constants (ADDR_LSB=17, RDNOW_BIT=35, WDATA_LSB=3, WDATA_MSB=34)
- One sub-module, `ocimem_seq_timer`: a loadable, saturating up-counter with terminal-count output. It is instantiated only under OCIMEM_SEQ_TIMEOUT_EN.

Test Plan:
- Address load: ocimem_a with jdo ADDR=0x10, RDNOW=0 -> MonAReg=0x10, mem_req stays 0, monitor_ready=1.
- Write: ocimem_b with WDATA=0xDEADBEEF at MonAReg=0x10, ack after 3 cycles -> mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, MonAReg=0x11, monitor_ready returns to 1.
- Read with wrap: MonAReg=0xFF, no_action_a, ack with rdata=0x12345678 -> MonDReg=0x12345678, MonAReg=0x00.
- Busy collision: ocimem_b issued during an outstanding read -> monitor_error=1, read completes normally. A subsequent ocimem_a clears monitor_error to 0.
- Simultaneous strobes: ocimem_a (ADDR=0x20) and ocimem_b in the same cycle -> only the address loads, no write issued.
- Timeout (macro defined, TIMEOUT_CYC=8): read with ack withheld -> mem_req drops after 8 cycles, monitor_error=1, MonAReg unchanged. Reset pulsed mid-access -> mem_req=0 asynchronously, monitor_ready=1.
